// File: rtl/md_sched.sv
// md_sched: multiply/divide scheduler beside the E stage; owns HI/LO, runs
// mult/div for a fixed latency and requests D-stage stalls while busy.
module md_sched #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        cancel,
    input  logic        md_use,
    output logic        busy,
    output logic        stall,
    output logic [31:0] hi,
    output logic [31:0] lo
);
    typedef enum logic {IDLE, RUN} state_t;
    localparam logic [3:0] MC = 4'(MULT_CYCLES);
    localparam logic [3:0] DC = 4'(DIV_CYCLES);
    state_t state;
    logic [3:0] cnt;
    logic [63:0] res, nres, uprod;
    logic signed [63:0] sprod;
    logic [31:0] d, sq, sr, uq, ur;
    logic div0;
    // divide-by-zero results are discarded, so a dummy divisor keeps the divider defined
    always_comb begin
        d = (b == 32'd0) ? 32'd1 : b;
        sprod = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
        uprod = {32'd0, a} * {32'd0, b};
        sq = $signed(a) / $signed(d);
        sr = $signed(a) % $signed(d);
        uq = a / d;
        ur = a % d;
        nres = (op[1:0] == 2'd0) ? sprod :
               (op[1:0] == 2'd1) ? uprod :
               (op[1:0] == 2'd2) ? {sr, sq} : {ur, uq};
    end
    assign stall = md_use & (busy | (start & ~op[2]));
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            busy  <= 1'b0;
            cnt   <= 4'd0;
            res   <= 64'd0;
            div0  <= 1'b0;
            hi    <= 32'd0;
            lo    <= 32'd0;
        end else if (state == RUN) begin
            if (cancel) begin
                state <= IDLE;
                busy  <= 1'b0;
                cnt   <= 4'd0;
                div0  <= 1'b0;
            end else begin
                cnt <= cnt - 4'd1;
                if (cnt == 4'd1) begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    if (!div0) {hi, lo} <= res;
                end
            end
        end else if (start && !cancel) begin
            if (!op[2]) begin
                state <= RUN;
                busy  <= 1'b1;
                res   <= nres;
                cnt   <= op[1] ? DC : MC;
                div0  <= op[1] & (b == 32'd0);
            end else if (op == 3'd4) begin
                hi <= a;
            end else if (op == 3'd5) begin
                lo <= a;
            end
        end
    end
endmodule

// File: tb/tb_md_sched.sv
// tb_md_sched: randomized and directed checks of md_sched against an
// arithmetic reference model of HI/LO and operation latency.
module tb_md_sched;
    localparam int MC = 5;
    localparam int DC = 10;
    logic clk = 0, reset = 1, start = 0, cancel = 0, md_use = 0;
    logic [2:0] op = 0;
    logic [31:0] a = 0, b = 0;
    logic busy, stall;
    logic [31:0] hi, lo;
    logic [31:0] exp_hi = 0, exp_lo = 0;
    int nchk = 0, nerr = 0;

    md_sched #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
        .cancel(cancel), .md_use(md_use), .busy(busy), .stall(stall),
        .hi(hi), .lo(lo));

    always #5 clk = ~clk;

    // reference: plain arithmetic on HI/LO plus the expected busy length
    task automatic model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y, output int n);
        longint la, lb, qm, q;
        longint unsigned ux, uy;
        la = longint'($signed(x));
        lb = longint'($signed(y));
        ux = x;
        uy = y;
        n = 0;
        case (o)
            3'd0: begin {exp_hi, exp_lo} = la * lb; n = MC; end
            3'd1: begin {exp_hi, exp_lo} = ux * uy; n = MC; end
            3'd2: begin
                n = DC;
                if (y != 0) begin
                    qm = (la < 0 ? -la : la) / (lb < 0 ? -lb : lb);
                    q = ((la < 0) != (lb < 0)) ? -qm : qm;
                    exp_lo = q[31:0];
                    exp_hi = 32'(la - q * lb);
                end
            end
            3'd3: begin
                n = DC;
                if (y != 0) begin exp_lo = x / y; exp_hi = x % y; end
            end
            3'd4: exp_hi = x;
            3'd5: exp_lo = x;
            default: ;
        endcase
    endtask

    task automatic go(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        start = 1; op = o; a = x; b = y;
        @(posedge clk); #1;
        start = 0;
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (busy && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
    endtask

    task automatic test_reset;
        #1;
        nchk++; if (busy !== 1'b0) begin nerr++; $display("FAIL reset_busy got %0b want 0", busy); end
        nchk++; if (hi !== 32'd0 || lo !== 32'd0) begin nerr++; $display("FAIL reset_hilo got %h/%h want 0/0", hi, lo); end
        md_use = 1; start = 1; op = 3'd0; #1;
        nchk++; if (stall !== 1'b1) begin nerr++; $display("FAIL reset_stall_mult got %0b want 1", stall); end
        op = 3'd4; #1;
        nchk++; if (stall !== 1'b0) begin nerr++; $display("FAIL reset_stall_mthi got %0b want 0", stall); end
        start = 0; md_use = 0; op = 0;
        @(posedge clk); @(posedge clk); #1;
        reset = 0;
    endtask

    task automatic test_mult;
        int n, en;
        model(3'd0, 32'hFFFFFFFD, 32'd5, en);
        go(3'd0, 32'hFFFFFFFD, 32'd5);
        nchk++; if (hi !== 32'd0 || lo !== 32'd0) begin nerr++; $display("FAIL mult_hold got %h/%h want 0/0", hi, lo); end
        wait_idle(n);
        nchk++; if (n != en) begin nerr++; $display("FAIL mult_latency got %0d want %0d", n, en); end
        nchk++; if (hi !== 32'hFFFFFFFF || lo !== 32'hFFFFFFF1) begin nerr++; $display("FAIL mult_result got %h/%h want ffffffff/fffffff1", hi, lo); end
        model(3'd1, 32'hFFFFFFFF, 32'd2, en);
        go(3'd1, 32'hFFFFFFFF, 32'd2);
        wait_idle(n);
        nchk++; if (n != MC || hi !== 32'h1 || lo !== 32'hFFFFFFFE) begin nerr++; $display("FAIL multu got n=%0d %h/%h want n=%0d 00000001/fffffffe", n, hi, lo, MC); end
    endtask

    task automatic test_div;
        int n, en;
        model(3'd2, 32'hFFFFFFF9, 32'd2, en);
        go(3'd2, 32'hFFFFFFF9, 32'd2);
        wait_idle(n);
        nchk++; if (n != DC) begin nerr++; $display("FAIL div_latency got %0d want %0d", n, DC); end
        nchk++; if (hi !== 32'hFFFFFFFF || lo !== 32'hFFFFFFFD) begin nerr++; $display("FAIL div_result got %h/%h want ffffffff/fffffffd", hi, lo); end
        model(3'd3, 32'd7, 32'd2, en);
        go(3'd3, 32'd7, 32'd2);
        wait_idle(n);
        nchk++; if (hi !== 32'd1 || lo !== 32'd3) begin nerr++; $display("FAIL divu_result got %h/%h want 1/3", hi, lo); end
    endtask

    task automatic test_div0_mthi;
        int n, en;
        model(3'd4, 32'h11, 32'd0, en);
        go(3'd4, 32'h11, 32'd0);
        nchk++; if (hi !== 32'h11 || busy !== 1'b0) begin nerr++; $display("FAIL mthi got hi=%h busy=%0b want 11/0", hi, busy); end
        model(3'd5, 32'h22, 32'd0, en);
        go(3'd5, 32'h22, 32'd0);
        nchk++; if (lo !== 32'h22 || busy !== 1'b0) begin nerr++; $display("FAIL mtlo got lo=%h busy=%0b want 22/0", lo, busy); end
        model(3'd2, 32'd123, 32'd0, en);
        go(3'd2, 32'd123, 32'd0);
        wait_idle(n);
        nchk++; if (n != DC) begin nerr++; $display("FAIL div0_latency got %0d want %0d", n, DC); end
        nchk++; if (hi !== 32'h11 || lo !== 32'h22) begin nerr++; $display("FAIL div0_hilo got %h/%h want 11/22", hi, lo); end
    endtask

    task automatic test_stall;
        int bad, n, en;
        bad = 0;
        md_use = 1; start = 1; op = 3'd0; a = 32'd3; b = 32'd4;
        model(3'd0, 32'd3, 32'd4, en);
        #1;
        nchk++; if (stall !== 1'b1) begin nerr++; $display("FAIL stall_start got %0b want 1", stall); end
        @(posedge clk); #1;
        op = 3'd2; a = 32'd100; b = 32'd3;
        for (int i = 0; i < MC; i++) begin
            if (stall !== 1'b1 || busy !== 1'b1) bad++;
            @(posedge clk); #1;
            start = 0;
        end
        nchk++; if (bad != 0) begin nerr++; $display("FAIL stall_busy got %0d bad cycles want 0", bad); end
        nchk++; if (stall !== 1'b0 || busy !== 1'b0) begin nerr++; $display("FAIL stall_release got stall=%0b busy=%0b want 0/0", stall, busy); end
        nchk++; if (hi !== exp_hi || lo !== exp_lo) begin nerr++; $display("FAIL ignored_start got %h/%h want %h/%h", hi, lo, exp_hi, exp_lo); end
        md_use = 0; bad = 0;
        model(3'd1, 32'd9, 32'd9, en);
        start = 1; op = 3'd1; a = 32'd9; b = 32'd9;
        for (int i = 0; i <= MC; i++) begin
            #1; if (stall !== 1'b0) bad++;
            @(posedge clk); #1;
            start = 0;
        end
        wait_idle(n);
        nchk++; if (bad != 0 || lo !== 32'd81) begin nerr++; $display("FAIL no_use_stall got %0d stalls lo=%h want 0 lo=51", bad, lo); end
    endtask

    task automatic test_cancel;
        int n, en;
        go(3'd4, 32'hAAAA, 0); model(3'd4, 32'hAAAA, 0, en);
        go(3'd5, 32'hBBBB, 0); model(3'd5, 32'hBBBB, 0, en);
        go(3'd2, 32'd100, 32'd7);
        @(posedge clk); #1;
        @(posedge clk); #1;
        cancel = 1;
        @(posedge clk); #1;
        cancel = 0;
        nchk++; if (busy !== 1'b0) begin nerr++; $display("FAIL cancel_busy got %0b want 0", busy); end
        nchk++; if (hi !== 32'hAAAA || lo !== 32'hBBBB) begin nerr++; $display("FAIL cancel_hilo got %h/%h want 0000aaaa/0000bbbb", hi, lo); end
        cancel = 1;
        go(3'd4, 32'h5555, 0);
        cancel = 0;
        nchk++; if (hi !== 32'hAAAA || busy !== 1'b0) begin nerr++; $display("FAIL cancel_idle got hi=%h busy=%0b want 0000aaaa/0", hi, busy); end
        model(3'd0, 32'd6, 32'd7, en);
        go(3'd0, 32'd6, 32'd7);
        wait_idle(n);
        nchk++; if (n != MC || hi !== 32'd0 || lo !== 32'd42) begin nerr++; $display("FAIL after_cancel got n=%0d %h/%h want n=%0d 0/2a", n, hi, lo, MC); end
    endtask

    task automatic test_async_reset;
        int n, en;
        go(3'd4, 32'h1234, 0);
        go(3'd3, 32'd1000, 32'd3);
        @(posedge clk); #3;
        reset = 1; #1;
        nchk++; if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin nerr++; $display("FAIL async_reset got busy=%0b %h/%h want 0 0/0", busy, hi, lo); end
        #1 reset = 0;
        exp_hi = 0; exp_lo = 0;
        @(posedge clk); #1;
        nchk++; if (busy !== 1'b0) begin nerr++; $display("FAIL reset_release_busy got %0b want 0", busy); end
        model(3'd3, 32'd1000, 32'd3, en);
        go(3'd3, 32'd1000, 32'd3);
        wait_idle(n);
        nchk++; if (n != DC || hi !== 32'd1 || lo !== 32'd333) begin nerr++; $display("FAIL post_reset_divu got n=%0d %h/%h want n=%0d 1/14d", n, hi, lo, DC); end
    endtask

    task automatic test_random;
        int n, en;
        logic [2:0] o;
        logic [31:0] x, y;
        for (int i = 0; i < 40; i++) begin
            o = 3'($urandom_range(0, 7));
            x = $urandom;
            y = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 9)) : $urandom;
            if ($urandom_range(0, 2) == 0) y = -y;
            if (o == 3'd2 && x == 32'h80000000 && y == 32'hFFFFFFFF) y = 32'd1;
            model(o, x, y, en);
            go(o, x, y);
            if (en != 0) wait_idle(n);
            else n = busy ? 99 : 0;
            nchk++; if (n != en || hi !== exp_hi || lo !== exp_lo) begin
                nerr++;
                $display("FAIL random op=%0d a=%h b=%h got n=%0d %h/%h want n=%0d %h/%h", o, x, y, n, hi, lo, en, exp_hi, exp_lo);
            end
        end
    endtask

    initial begin
        test_reset;
        test_mult;
        test_div;
        test_div0_mthi;
        test_stall;
        test_cancel;
        test_async_reset;
        test_random;
        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule
